// File: rtl/mic_pkg.sv
// Shared types and sizes for the microphone LED display path.
// Pure declarations: no logic, no latency.
// No flow control: consumers sample these constants at elaboration.
package mic_pkg;

    localparam int LED_W   = 12;
    localparam int BAR_MAX = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/led_bar_enc.sv
// Thermometer encoder: peak >> BAR_SHIFT ones from bit 0, saturating at BAR_MAX.
// Latency: purely combinational.
// Backpressure: none; output follows input every cycle.
module led_bar_enc
    import mic_pkg::*;
#(
    parameter int BAR_SHIFT = 8
) (
    input  logic [LED_W-1:0] peak,
    output logic [LED_W-1:0] bar
);

    logic [LED_W-1:0] shifted;

    // Bit i lights when the bar length exceeds i; lengths above BAR_MAX saturate naturally.
    always_comb begin
        shifted = peak >> BAR_SHIFT;
        bar     = '0;
        for (int i = 0; i < BAR_MAX; i++) begin
            bar[i] = (shifted > LED_W'(i));
        end
    end

endmodule

// File: rtl/mic_led_ctrl.sv
// Microphone LED controller: raw sample or windowed peak-hold bar graph on 12 LEDs.
// Latency: led one CLK after sample_tick (mode 0) or after peak update (mode 1).
// Backpressure: none; sample_tick is accepted every CLK it is high.
module mic_led_ctrl
    import mic_pkg::*;
#(
    parameter int WINDOW_SAMPLES = 4000,
    parameter int BAR_SHIFT      = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             E,
    input  logic             mode,
    input  logic             sample_tick,
    input  logic [LED_W-1:0] mic_in,
    output logic [LED_W-1:0] led,
    output logic [LED_W-1:0] peak,
    output logic             peak_valid
);

    localparam int                CNT_W    = $clog2(WINDOW_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_SAMPLES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d, base_cnt, next_cnt;
    logic [LED_W-1:0]   run_max_q, run_max_d, base_max;
    logic [LED_W-1:0]   raw_q, led_d, bar;
    logic               publish;

    led_bar_enc #(
        .BAR_SHIFT (BAR_SHIFT)
    ) u_bar (
        .peak (peak),
        .bar  (bar)
    );

    // A window continues from the held totals only in ACCUM; PUBLISH and IDLE start from zero,
    // which lets a tick coincident with PUBLISH open the next window.
    always_comb begin
        base_cnt = (state_q == ST_ACCUM) ? count_q   : '0;
        base_max = (state_q == ST_ACCUM) ? run_max_q : '0;
        next_cnt = base_cnt + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_ACCUM;
            end
            ST_ACCUM, ST_PUBLISH: begin
                state_d = (sample_tick && next_cnt == CNT_LAST) ? ST_PUBLISH : ST_ACCUM;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!E) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        count_d   = base_cnt;
        run_max_d = base_max;
        if (sample_tick) begin
            count_d   = next_cnt;
            run_max_d = (mic_in > base_max) ? mic_in : base_max;
        end
        if (state_q == ST_IDLE || !E) begin
            count_d   = '0;
            run_max_d = '0;
        end
        publish = (state_q == ST_PUBLISH) && E;
        if (!E) begin
            led_d = '0;
        end else if (mode) begin
            led_d = bar;
        end else begin
            led_d = sample_tick ? mic_in : raw_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            count_q    <= '0;
            run_max_q  <= '0;
            raw_q      <= '0;
            peak       <= '0;
            peak_valid <= 1'b0;
            led        <= '0;
        end else begin
            count_q    <= count_d;
            run_max_q  <= run_max_d;
            if (sample_tick) begin
                raw_q <= mic_in;
            end
            if (publish) begin
                peak <= run_max_q;
            end
            peak_valid <= publish;
            led        <= led_d;
        end
    end

endmodule

// File: tb/tb_mic_led_ctrl.sv
// Directed and randomized bench for mic_led_ctrl against a window/queue reference model.
module tb_mic_led_ctrl;

    localparam int W  = 4;
    localparam int SH = 8;

    logic        CLK = 1'b0;
    logic        rst_n, E, mode, sample_tick;
    logic [11:0] mic_in, led, peak;
    logic        peak_valid;

    always #5 CLK = ~CLK;

    mic_led_ctrl #(
        .WINDOW_SAMPLES (W),
        .BAR_SHIFT      (SH)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .E           (E),
        .mode        (mode),
        .sample_tick (sample_tick),
        .mic_in      (mic_in),
        .led         (led),
        .peak        (peak),
        .peak_valid  (peak_valid)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: samples of the open window, plus a completed window awaiting publication.
    bit          armed;
    logic [11:0] win[$];
    bit          pend;
    logic [11:0] pend_val;
    logic [11:0] m_peak, m_led, m_raw;
    logic        m_pv;

    function automatic logic [11:0] bar_of(input logic [11:0] p);
        int n;
        n = int'(p) / (1 << SH);
        if (n > 12) n = 12;
        return 12'((1 << n) - 1);
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s @cyc%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic m, input logic t, input logic [11:0] d);
        logic [11:0] nled, mx;
        if (!r) begin
            armed = 0; win.delete(); pend = 0;
            m_peak = '0; m_pv = 0; m_led = '0; m_raw = '0;
        end else begin
            nled = !e ? 12'h000 : (m ? bar_of(m_peak) : (t ? d : m_raw));
            if (t) m_raw = d;
            m_pv = 0;
            if (!e) begin
                armed = 0; win.delete(); pend = 0;
            end else if (!armed) begin
                armed = 1; win.delete();
            end else begin
                if (pend) begin
                    m_peak = pend_val; m_pv = 1; pend = 0;
                end
                if (t) begin
                    win.push_back(d);
                    if (win.size() == W) begin
                        mx = '0;
                        foreach (win[i]) if (win[i] > mx) mx = win[i];
                        pend = 1; pend_val = mx; win.delete();
                    end
                end
            end
            m_led = nled;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic m, input logic t, input logic [11:0] d);
        rst_n = r; E = e; mode = m; sample_tick = t; mic_in = d;
        @(posedge CLK);
        cyc++;
        model(r, e, m, t, d);
        #1;
        chk("led", led, m_led);
        chk("peak", peak, m_peak);
        chk("peak_valid", {11'd0, peak_valid}, {11'd0, m_pv});
    endtask

    logic r_r, r_e, r_m, r_t;

    initial begin
        rst_n = 1'b0; E = 1'b0; mode = 1'b0; sample_tick = 1'b0; mic_in = '0;
        #2;
        step(0, 1, 1, 1, 12'hABC);
        chk("reset_led", led, 12'h000);
        chk("reset_peak", peak, 12'h000);

        // Raw sample path
        step(1, 1, 0, 0, 12'h000);
        step(1, 1, 0, 1, 12'h5A3);
        chk("raw_led", led, 12'h5A3);
        chk("raw_peak", peak, 12'h000);

        // One full window with a no-tick publish cycle
        step(0, 0, 1, 0, 12'h000);
        step(1, 1, 1, 0, 12'h000);
        step(1, 1, 1, 1, 12'h100);
        step(1, 1, 1, 1, 12'h7FF);
        step(1, 1, 1, 0, 12'h000);
        step(1, 1, 1, 1, 12'h300);
        step(1, 1, 1, 1, 12'h050);
        chk("pv_early", {11'd0, peak_valid}, 12'h000);
        step(1, 1, 1, 0, 12'h000);
        chk("win_peak", peak, 12'h7FF);
        chk("win_pv", {11'd0, peak_valid}, 12'h001);
        step(1, 1, 1, 0, 12'h000);
        chk("win_pv_once", {11'd0, peak_valid}, 12'h000);
        chk("bar7", led, 12'h07F);

        // Tick coincident with publish opens the next window
        repeat (4) step(1, 1, 1, 1, 12'h200);
        step(1, 1, 1, 1, 12'hC00);
        chk("pub_peak200", peak, 12'h200);
        repeat (3) step(1, 1, 1, 1, 12'h000);
        step(1, 1, 1, 0, 12'h000);
        chk("pub_tick_peak", peak, 12'hC00);
        step(1, 1, 1, 0, 12'h000);
        chk("bar12", led, 12'hFFF);

        // Enable drop discards the partial window
        repeat (2) step(1, 1, 1, 1, 12'hF00);
        step(1, 0, 1, 0, 12'h000);
        chk("e_off_led", led, 12'h000);
        chk("e_off_peak", peak, 12'hC00);
        step(1, 1, 1, 0, 12'h000);
        repeat (3) step(1, 1, 1, 1, 12'h400);
        step(1, 1, 1, 0, 12'h000);
        chk("e_partial_nopv", {11'd0, peak_valid}, 12'h000);
        step(1, 1, 1, 1, 12'h400);
        step(1, 1, 1, 0, 12'h000);
        chk("e_new_peak", peak, 12'h400);

        // Reset mid-window
        repeat (2) step(1, 1, 1, 1, 12'hE00);
        step(0, 1, 1, 1, 12'hE00);
        chk("rst_mid_led", led, 12'h000);
        chk("rst_mid_peak", peak, 12'h000);
        step(1, 1, 1, 0, 12'h000);
        repeat (4) step(1, 1, 1, 1, 12'h333);
        step(1, 1, 1, 0, 12'h000);
        chk("rst_new_peak", peak, 12'h333);

        // Mode toggles mid-window leave accumulation alone
        step(1, 1, 1, 1, 12'h123);
        step(1, 1, 0, 1, 12'h9AB);
        step(1, 1, 1, 1, 12'h456);
        step(1, 1, 1, 1, 12'h001);
        step(1, 1, 1, 0, 12'h000);
        chk("toggle_peak", peak, 12'h9AB);
        chk("toggle_pv", {11'd0, peak_valid}, 12'h001);

        // Randomized traffic
        r_m = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r_r = ($urandom_range(0, 299) != 0);
            r_e = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 39) == 0) r_m = ~r_m;
            r_t = ($urandom_range(0, 2) == 0) || ($urandom_range(0, 9) == 0);
            step(r_r, r_e, r_m, r_t, 12'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mic_led_ctrl.md
MIC_LED_CTRL -- requirements
Module: mic_led_ctrl

Interface
REQ-001 Parameter WINDOW_SAMPLES, default 4000: number of sample_tick strobes per peak window (0.2 s at 20 kHz).
REQ-002 Parameter BAR_SHIFT, default 8: right-shift applied to the peak to form the bar length.
REQ-003 CLK  input  1  system clock; single clock domain.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 E  input  1  display enable (switch); 0 blanks the LEDs and halts accumulation.
REQ-006 mode  input  1  0 = gated raw sample to LEDs; 1 = peak-hold bar graph.
REQ-007 sample_tick  input  1  one-CLK strobe marking mic_in valid.
REQ-008 mic_in  input  12  unsigned microphone sample.
REQ-009 led  output  12  LED drive, registered.
REQ-010 peak  output  12  last published window peak, registered, for the 7-segment path.
REQ-011 peak_valid  output  1  one-CLK pulse when peak updates.

Function
REQ-012 The FSM SHALL have states IDLE, ACCUM and PUBLISH, encoded in a 2-bit register.
REQ-013 IDLE: when E=1 on a CLK edge, go to ACCUM; clear sample count and running max.
REQ-014 ACCUM: on each sample_tick, running_max <= max(running_max, mic_in) and count <= count+1.
REQ-015 ACCUM: when a sample_tick brings count to WINDOW_SAMPLES, go to PUBLISH on the same edge; that sample is included in the max.
REQ-016 PUBLISH lasts exactly one CLK: peak <= running_max; peak_valid=1; count <= 0; running_max <= 0; next state is ACCUM.
REQ-017 A sample_tick arriving in the PUBLISH cycle SHALL be the first sample of the new window (count <= 1, running_max <= mic_in).
REQ-018 E=0 in any state SHALL force IDLE on the next edge; the partial window is discarded; peak keeps its last value.
REQ-019 In mode 0 with E=1, led SHALL equal the mic_in captured at the most recent sample_tick; latency is one CLK from sample_tick.
REQ-020 In mode 1 with E=1, led SHALL be a thermometer code of n = min(peak >> BAR_SHIFT, 12) ones from bit 0 upward; latency is one CLK after peak updates.
REQ-021 With E=0, led SHALL be 12'h000 from the next edge, in both modes.
REQ-022 Changing mode SHALL NOT disturb accumulation, count or peak; only led selection changes, on the next edge.
REQ-023 The count SHALL be sized as clog2(WINDOW_SAMPLES+1) bits and SHALL never exceed WINDOW_SAMPLES.
REQ-024 The running max compare SHALL be unsigned 12-bit; mic_in=12'hFFF SHALL saturate to bar n=12.
REQ-025 sample_tick held high for several CLKs SHALL count once per CLK; a one-CLK strobe is the supported contract.

Reset
REQ-026 rst_n=0 on a CLK edge SHALL set state=IDLE, count=0, running_max=0, peak=0, peak_valid=0, led=0, and the raw sample register to 0.
REQ-027 Reset mid-window SHALL discard all accumulation, with no peak_valid pulse.
REQ-028 Reset SHALL take priority over E, sample_tick and mode.

Structure
REQ-029 The state encodings, the LED width (12) and the maximum bar length (12) SHALL live in the shared package mic_pkg.
REQ-030 The thermometer encoding SHALL be a combinational sub-module led_bar_enc (12-bit peak in, 12-bit bar out, BAR_SHIFT parameter); all other logic stays in mic_led_ctrl.

Verification
REQ-031 Reset then E=1, mode=0, one tick with mic_in=12'h5A3 -> led=12'h5A3 one CLK after the tick; peak=0.
REQ-032 WINDOW_SAMPLES=4, E=1, mode=1, ticks 12'h100, 12'h7FF, 12'h300, 12'h050 -> PUBLISH follows the 4th tick, peak=12'h7FF, peak_valid for 1 CLK, then led=12'h07F (n=7).
REQ-033 Tick coincident with PUBLISH carrying 12'hC00, then 3 ticks of 12'h000 -> next peak=12'hC00 and led=12'hFFF (n=12).
REQ-034 E dropped after 2 of 4 ticks -> led=0 next CLK, no peak_valid, peak unchanged; on E=1 a full new window is required before any publish.
REQ-035 rst_n=0 for one CLK mid-window with mode=1 -> all outputs 0; a fresh window publishes only after 4 further ticks.
REQ-036 Toggle mode 1->0->1 mid-window -> peak and publish timing are identical to a run with no toggle.
